// File: rtl/sccb_slave_responder.sv
// sccb_slave_responder
//   SCCB/I2C target that answers at DEVICE_ADDR. SCL and SDA are oversampled
//   in the sys_clk domain. Writes are presented on a register-file strobe
//   port. Reads are served from reg_rd_data and driven onto SDA open-drain.
//
// Parameters
//   DEVICE_ADDR  7-bit address this block acknowledges
//   ADDR_BYTES   register address length, 1 or 2 (high byte first)
//
// Ports
//   sys_clk      system clock (>= 16x SCL)
//   sys_rst      asynchronous active-high reset
//   scl_in       bus SCL (asynchronous)
//   sda_in       bus SDA (asynchronous)
//   sda_oe       1 = pull SDA low, 0 = release
//   reg_wr_en    one-cycle write strobe
//   reg_addr     current register pointer
//   reg_wr_data  write data, valid with reg_wr_en
//   reg_rd_data  read data for reg_addr, sampled on SCL falls
//   busy         high from START until STOP or abort
module sccb_slave_responder #(
   parameter logic [6:0] DEVICE_ADDR = 7'h21,
   parameter int         ADDR_BYTES  = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic        reg_wr_en,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wr_data,
   input  logic [7:0]  reg_rd_data,
   output logic        busy
);

   localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
   localparam logic [1:0] ADDR_END  = 2'(ADDR_BYTES);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
      WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [1:0]  addr_cnt, addr_cnt_nxt;
   logic [15:0] reg_addr_nxt;
   logic [7:0]  wr_data_nxt;
   logic        wr_en_nxt, oe_nxt, busy_nxt;
   logic [7:0]  shreg, shreg_nxt;
   logic [7:0]  addr_hi, addr_hi_nxt;
   logic        rw_bit, rw_nxt;

   logic scl_p0, scl_p1, scl_p2;
   logic sda_p0, sda_p1, sda_p2;
   logic scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte;
   logic       last_bit;

   // Register pointer increment; a 1-byte pointer wraps within its low byte.
   function automatic logic [15:0] addr_inc(input logic [15:0] a);
      if (ADDR_BYTES == 2) return a + 16'd1;
      else                 return {8'h00, a[7:0] + 8'd1};
   endfunction

   // Stage p0/p1: two-flop synchronizer; p2: history for edge detection.
   // Idle-high reset keeps a false START from appearing after reset.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
         sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= scl_in; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
         sda_p0 <= sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
      end
   end

   assign scl_rise  =  scl_p1 & ~scl_p2;
   assign scl_fall  = ~scl_p1 &  scl_p2;
   assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
   assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
   assign rx_byte   = {shreg[6:0], sda_p1};
   assign last_bit  = (bit_cnt == 4'd7);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= IDLE;
         bit_cnt     <= 4'd0;
         addr_cnt    <= 2'd0;
         reg_addr    <= 16'h0000;
         reg_wr_data <= 8'h00;
         reg_wr_en   <= 1'b0;
         sda_oe      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= bit_cnt_nxt;
         addr_cnt    <= addr_cnt_nxt;
         reg_addr    <= reg_addr_nxt;
         reg_wr_data <= wr_data_nxt;
         reg_wr_en   <= wr_en_nxt;
         sda_oe      <= oe_nxt;
         busy        <= busy_nxt;
      end
   end

   always_ff @(posedge sys_clk) begin
      shreg   <= shreg_nxt;
      addr_hi <= addr_hi_nxt;
      rw_bit  <= rw_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      addr_cnt_nxt = addr_cnt;
      reg_addr_nxt = reg_addr;
      wr_data_nxt  = reg_wr_data;
      wr_en_nxt    = 1'b0;
      oe_nxt       = sda_oe;
      busy_nxt     = busy;
      shreg_nxt    = shreg;
      addr_hi_nxt  = addr_hi;
      rw_nxt       = rw_bit;

      // START outranks any same-cycle SCL edge, and both bus conditions
      // override whatever the state machine is doing.
      if (start_det) begin
         state_nxt    = DEV_ADDR;
         bit_cnt_nxt  = 4'd0;
         addr_cnt_nxt = 2'd0;
         oe_nxt       = 1'b0;
         busy_nxt     = 1'b1;
      end else if (stop_det) begin
         state_nxt   = IDLE;
         bit_cnt_nxt = 4'd0;
         oe_nxt      = 1'b0;
         busy_nxt    = 1'b0;
      end else begin
         case (state)
            DEV_ADDR: if (scl_rise) begin
               shreg_nxt   = rx_byte;
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (last_bit) begin
                  rw_nxt    = sda_p1;
                  state_nxt = (shreg[6:0] == DEVICE_ADDR) ? DEV_ACK : IGNORE;
               end
            end
            // ACK slots: the first fall asserts SDA, the fall after the
            // 9th clock releases it and moves on.
            DEV_ACK: if (scl_fall) begin
               if (!sda_oe) oe_nxt = 1'b1;
               else begin
                  bit_cnt_nxt = 4'd0;
                  if (rw_bit) begin
                     shreg_nxt = reg_rd_data;
                     oe_nxt    = ~reg_rd_data[7];
                     state_nxt = RD_DATA;
                  end else begin
                     oe_nxt    = 1'b0;
                     state_nxt = REG_ADDR;
                  end
               end
            end
            REG_ADDR: if (scl_rise) begin
               shreg_nxt   = rx_byte;
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (last_bit) begin
                  addr_cnt_nxt = addr_cnt + 2'd1;
                  if (addr_cnt == ADDR_LAST)
                     reg_addr_nxt = (ADDR_BYTES == 2) ? {addr_hi, rx_byte}
                                                      : {8'h00, rx_byte};
                  else
                     addr_hi_nxt = rx_byte;
                  state_nxt = REG_ACK;
               end
            end
            REG_ACK: if (scl_fall) begin
               if (!sda_oe) oe_nxt = 1'b1;
               else begin
                  oe_nxt      = 1'b0;
                  bit_cnt_nxt = 4'd0;
                  state_nxt   = (addr_cnt == ADDR_END) ? WR_DATA : REG_ADDR;
               end
            end
            WR_DATA: if (scl_rise) begin
               shreg_nxt   = rx_byte;
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (last_bit) begin
                  wr_data_nxt = rx_byte;
                  wr_en_nxt   = 1'b1;
                  state_nxt   = WR_ACK;
               end
            end
            WR_ACK: if (scl_fall) begin
               if (!sda_oe) oe_nxt = 1'b1;
               else begin
                  oe_nxt       = 1'b0;
                  bit_cnt_nxt  = 4'd0;
                  reg_addr_nxt = addr_inc(reg_addr);
                  state_nxt    = WR_DATA;
               end
            end
            // Bit 7 goes out when the byte is loaded; each later fall drives
            // the next lower bit, and the fall after bit 0 frees SDA for the
            // master's ACK.
            RD_DATA: begin
               if (scl_rise && bit_cnt != 4'd8) bit_cnt_nxt = bit_cnt + 4'd1;
               else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_nxt    = 1'b0;
                     state_nxt = RD_ACK;
                  end else
                     oe_nxt = ~shreg[3'd7 - bit_cnt[2:0]];
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (sda_p1) state_nxt = IGNORE;
                  else        reg_addr_nxt = addr_inc(reg_addr);
               end else if (scl_fall) begin
                  shreg_nxt   = reg_rd_data;
                  oe_nxt      = ~reg_rd_data[7];
                  bit_cnt_nxt = 4'd0;
                  state_nxt   = RD_DATA;
               end
            end
            IDLE, IGNORE: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_slave_responder.sv
`timescale 1ns/1ps
module tb_sccb_slave_responder;

   localparam int Q = 160;   // quarter SCL period: 8 sys_clk cycles

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        scl     = 1'b1;
   logic        sda_m   = 1'b1;
   logic        sda_oe1, sda_oe2, wr_en1, wr_en2, busy1, busy2;
   logic [15:0] addr1, addr2;
   logic [7:0]  wdata1, wdata2;
   wire  [7:0]  rd1 = addr1[7:0] + 8'h80;
   wire  [7:0]  rd2 = addr2[7:0] ^ addr2[15:8];
   wire         sda_line = sda_m & ~sda_oe1 & ~sda_oe2;

   int checks = 0;
   int errors = 0;
   int oe1_cycles = 0;
   logic [23:0] exp_wr1[$];
   logic [23:0] exp_wr2[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  rd_obs[$];

   always #10 sys_clk = ~sys_clk;

   sccb_slave_responder #(.DEVICE_ADDR(7'h21), .ADDR_BYTES(1)) u_dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .scl_in(scl), .sda_in(sda_line),
      .sda_oe(sda_oe1), .reg_wr_en(wr_en1), .reg_addr(addr1),
      .reg_wr_data(wdata1), .reg_rd_data(rd1), .busy(busy1));

   sccb_slave_responder #(.DEVICE_ADDR(7'h3C), .ADDR_BYTES(2)) u_dut2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .scl_in(scl), .sda_in(sda_line),
      .sda_oe(sda_oe2), .reg_wr_en(wr_en2), .reg_addr(addr2),
      .reg_wr_data(wdata2), .reg_rd_data(rd2), .busy(busy2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_start();
      sda_m = 1'b1; #(Q); scl = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl = 1'b0; #(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #(Q); scl = 1'b1; #(Q); sda_m = 1'b1; #(Q);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
      logic ack;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; #(Q); scl = 1'b1; #(Q); ack = sda_line; #(Q); scl = 1'b0; #(Q);
      chk(name, {31'd0, ack}, {31'd0, exp_ack});
   endtask

   task automatic recv_byte(input logic mack);
      logic [7:0] d;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         sda_m = 1'b1; #(Q); scl = 1'b1; #(Q); d = {d[6:0], sda_line}; #(Q); scl = 1'b0; #(Q);
      end
      rd_obs.push_back(d);
      sda_m = mack; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
      sda_m = 1'b1;
   endtask

   task automatic mon_wr1();
      logic [23:0] e;
      forever begin
         @(negedge sys_clk);
         if (wr_en1) begin
            if (exp_wr1.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr1_unexpected addr=0x%0h data=0x%0h", addr1, wdata1);
            end else begin
               e = exp_wr1.pop_front();
               chk("wr1_addr_data", {8'h00, addr1, wdata1}, {8'h00, e});
            end
         end
      end
   endtask

   task automatic mon_wr2();
      logic [23:0] e;
      forever begin
         @(negedge sys_clk);
         if (wr_en2) begin
            if (exp_wr2.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr2_unexpected addr=0x%0h data=0x%0h", addr2, wdata2);
            end else begin
               e = exp_wr2.pop_front();
               chk("wr2_addr_data", {8'h00, addr2, wdata2}, {8'h00, e});
            end
         end
      end
   endtask

   task automatic mon_rd();
      logic [7:0] got;
      forever begin
         @(negedge sys_clk);
         if (rd_obs.size() > 0) begin
            got = rd_obs.pop_front();
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected got=0x%0h", got);
            end else
               chk("rd_byte", {24'd0, got}, {24'd0, exp_rd.pop_front()});
         end
      end
   endtask

   task automatic mon_oe();
      forever begin
         @(negedge sys_clk);
         if (sda_oe1) oe1_cycles++;
      end
   endtask

   initial begin
      int oe_before;
      fork
         mon_wr1();
         mon_wr2();
         mon_rd();
         mon_oe();
         begin
            #(1ms);
            $display("FAIL watchdog expired");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset state
      repeat (4) @(negedge sys_clk);
      chk("rst_sda_oe", {31'd0, sda_oe1}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en1}, 32'd0);
      chk("rst_addr", {16'd0, addr1}, 32'd0);
      chk("rst_wdata", {24'd0, wdata1}, 32'd0);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      sys_rst = 1'b0;
      repeat (4) @(negedge sys_clk);

      // Single write
      exp_wr1.push_back({16'h003A, 8'h55});
      bus_start();
      chk("t1_busy", {31'd0, busy1}, 32'd1);
      send_byte(8'h42, 1'b0, "t1_dev_ack");
      send_byte(8'h3A, 1'b0, "t1_reg_ack");
      send_byte(8'h55, 1'b0, "t1_data_ack");
      bus_stop();
      chk("t1_busy_after", {31'd0, busy1}, 32'd0);
      chk("t1_wr_pending", exp_wr1.size(), 32'd0);
      chk("t1_addr_inc", {16'd0, addr1}, 32'h003B);

      // Address mismatch
      oe_before = oe1_cycles;
      bus_start();
      send_byte(8'h44, 1'b1, "t2_dev_nack");
      send_byte(8'h10, 1'b1, "t2_byte_nack");
      bus_stop();
      chk("t2_oe_cycles", oe1_cycles - oe_before, 32'd0);
      chk("t2_addr_same", {16'd0, addr1}, 32'h003B);

      // Burst write with 8-bit wrap
      exp_wr1.push_back({16'h00FE, 8'h11});
      exp_wr1.push_back({16'h00FF, 8'h22});
      exp_wr1.push_back({16'h0000, 8'h33});
      bus_start();
      send_byte(8'h42, 1'b0, "t3_dev_ack");
      send_byte(8'hFE, 1'b0, "t3_reg_ack");
      send_byte(8'h11, 1'b0, "t3_d0_ack");
      send_byte(8'h22, 1'b0, "t3_d1_ack");
      send_byte(8'h33, 1'b0, "t3_d2_ack");
      bus_stop();
      chk("t3_wr_pending", exp_wr1.size(), 32'd0);
      chk("t3_addr_wrap", {16'd0, addr1}, 32'h0001);

      // Read with repeated START
      bus_start();
      send_byte(8'h42, 1'b0, "t4_dev_ack");
      send_byte(8'h20, 1'b0, "t4_reg_ack");
      bus_start();
      send_byte(8'h43, 1'b0, "t4_rd_ack");
      exp_rd.push_back(8'hA0);
      recv_byte(1'b0);
      exp_rd.push_back(8'hA1);
      recv_byte(1'b1);
      chk("t4_sda_released", {31'd0, sda_oe1}, 32'd0);
      bus_stop();
      chk("t4_rd_pending", exp_rd.size(), 32'd0);
      chk("t4_addr", {16'd0, addr1}, 32'h0021);
      chk("t4_busy", {31'd0, busy1}, 32'd0);

      // 16-bit register address
      exp_wr2.push_back({16'h3008, 8'h82});
      bus_start();
      send_byte(8'h78, 1'b0, "t5_dev_ack");
      send_byte(8'h30, 1'b0, "t5_hi_ack");
      send_byte(8'h08, 1'b0, "t5_lo_ack");
      send_byte(8'h82, 1'b0, "t5_data_ack");
      bus_stop();
      chk("t5_wr_pending", exp_wr2.size(), 32'd0);
      chk("t5_addr2", {16'd0, addr2}, 32'h3009);
      chk("t5_addr1_same", {16'd0, addr1}, 32'h0021);

      // STOP after 4 data bits: no write
      bus_start();
      send_byte(8'h42, 1'b0, "t6_dev_ack");
      send_byte(8'h10, 1'b0, "t6_reg_ack");
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      bus_stop();
      chk("t6_busy", {31'd0, busy1}, 32'd0);
      chk("t6_addr", {16'd0, addr1}, 32'h0010);

      // Reset while driving a 0 in RD_DATA
      bus_start();
      send_byte(8'h42, 1'b0, "t7_dev_ack");
      send_byte(8'h20, 1'b0, "t7_reg_ack");
      bus_start();
      send_byte(8'h43, 1'b0, "t7_rd_ack");
      send_bit(1'b1);
      chk("t7_driving0", {31'd0, sda_oe1}, 32'd1);
      sys_rst = 1'b1;
      #1;
      chk("t7_async_release", {31'd0, sda_oe1}, 32'd0);
      chk("t7_addr_reset", {16'd0, addr1}, 32'd0);
      #(Q);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      repeat (4) @(negedge sys_clk);
      bus_stop();
      exp_wr1.push_back({16'h003A, 8'h55});
      bus_start();
      send_byte(8'h42, 1'b0, "t7b_dev_ack");
      send_byte(8'h3A, 1'b0, "t7b_reg_ack");
      send_byte(8'h55, 1'b0, "t7b_data_ack");
      bus_stop();
      chk("t7b_wr_pending", exp_wr1.size(), 32'd0);
      chk("t7b_addr", {16'd0, addr1}, 32'h003B);
      chk("t7b_busy", {31'd0, busy1}, 32'd0);

      repeat (8) @(negedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
